// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter and write sequencer for a single shared DW-bit register.
//   One requester owns the register at a time. Ownership is capped at MAX_HOLD
//   cycles while someone else is waiting. Only the owner's writes land in Q.
module shared_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4,
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int HW      = $clog2(MAX_HOLD + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    wr_en,
    input  logic [N_REQ*DW-1:0] wr_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [DW-1:0]       Q,
    output logic [DW-1:0]       Q_bar,
    output logic                busy,
    output logic [IW-1:0]       owner_id
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [HW-1:0] hold_cnt;

    logic [N_REQ-1:0] others_req;
    logic [IW-1:0]    next_ptr;
    logic             hold_full;
    logic             release_now;
    logic             idle_found;
    logic [IW-1:0]    idle_idx;
    logic             rel_found;
    logic [IW-1:0]    rel_idx;
    logic [DW-1:0]    owner_data;

    // First set bit of vec, scanning ptr, ptr+1, ... modulo N_REQ.
    // The loop runs downward so the lowest offset overwrites any later hit.
    function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] vec,
                                            input logic [IW-1:0]    ptr);
        logic [IW:0] res;
        int          idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (vec[IW'(idx)]) res = {1'b1, IW'(idx)};
        end
        return res;
    endfunction

    assign busy  = (state == OWN);
    assign Q_bar = ~Q;

    // Arbitration decisions for the coming edge.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        others_req  = req & ~gnt;
        next_ptr    = (owner_id == IW'(N_REQ - 1)) ? '0 : owner_id + 1'b1;
        hold_full   = (hold_cnt == HW'(MAX_HOLD));
        release_now = !req[owner_id] || (hold_full && (|others_req));
        {idle_found, idle_idx} = rr_pick(req, rr_ptr);
        // The departing owner is masked, so the scan from owner+1 never picks it again.
        {rel_found, rel_idx}   = rr_pick(others_req, next_ptr);
        owner_data  = wr_data[owner_id*DW +: DW];
    end

    // Ownership FSM, round-robin pointer, hold counter and register commit.
    // NOTE: all state here uses non-blocking assignments, so every register
    //       sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner_id <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            Q        <= '0;
        end else begin
            // gnt is one-hot, so owner_id selects the only requester allowed
            // to write. A final write on the release cycle still lands.
            if (|(gnt & wr_en)) Q <= owner_data;

            case (state)
                IDLE: begin
                    if (idle_found) begin
                        state    <= OWN;
                        gnt      <= N_REQ'(1) << idle_idx;
                        owner_id <= idle_idx;
                        hold_cnt <= HW'(1);
                    end
                end
                default: begin
                    if (release_now) begin
                        rr_ptr <= next_ptr;
                        if (rel_found) begin
                            // Direct hand-off to the next requester with no idle gap.
                            gnt      <= N_REQ'(1) << rel_idx;
                            owner_id <= rel_idx;
                            hold_cnt <= HW'(1);
                        end else begin
                            state    <= IDLE;
                            gnt      <= '0;
                            owner_id <= '0;
                            hold_cnt <= '0;
                        end
                    end else if (!hold_full) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter
//   Directed scenarios for shared_reg_arbiter. Each stimulus row carries the
//   outputs expected after the edge that samples it. The expectation is queued
//   when the row is driven, then popped and compared once that edge has passed.
module tb_shared_reg_arbiter;

    localparam int N_REQ    = 4;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    wr_en;
    logic [N_REQ*DW-1:0] wr_data;
    logic [N_REQ-1:0]    gnt;
    logic [DW-1:0]       Q;
    logic [DW-1:0]       Q_bar;
    logic                busy;
    logic [1:0]          owner_id;

    shared_reg_arbiter #(.N_REQ(N_REQ), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .gnt      (gnt),
        .Q        (Q),
        .Q_bar    (Q_bar),
        .busy     (busy),
        .owner_id (owner_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [7:0] q_bar;
        logic       busy;
        logic [1:0] owner;
    } obs_t;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  wr_en;
        logic [31:0] data;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic        busy;
        logic [1:0]  owner;
    } row_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] d(input logic [7:0] d3, input logic [7:0] d2,
                                      input logic [7:0] d1, input logic [7:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    function automatic row_t mk(input logic r, input logic [3:0] rq, input logic [3:0] we,
                                input logic [31:0] dat, input logic [3:0] g,
                                input logic [7:0] q, input logic b, input logic [1:0] own);
        row_t x;
        x.rst = r; x.req = rq; x.wr_en = we; x.data = dat;
        x.gnt = g; x.q = q; x.busy = b; x.owner = own;
        return x;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.gnt = gnt; o.q = Q; o.q_bar = Q_bar; o.busy = busy; o.owner = owner_id;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("gnt=%b Q=%h Q_bar=%h busy=%b owner=%0d",
                         o.gnt, o.q, o.q_bar, o.busy, o.owner);
    endfunction

    // Drive one row and queue the outputs expected after the sampling edge.
    task automatic drive(input row_t r);
        obs_t e;
        rst = r.rst; req = r.req; wr_en = r.wr_en; wr_data = r.data;
        e.gnt = r.gnt; e.q = r.q; e.q_bar = ~r.q; e.busy = r.busy; e.owner = r.owner;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; wr_en = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        row_t t[$];
        obs_t e;
        t.push_back(mk(1, 4'b1111, 4'b1111, d(8'hA5, 8'hA5, 8'hA5, 8'hA5), 4'b0000, 8'h00, 0, 0));
        t.push_back(mk(1, 4'b1111, 4'b1111, d(8'hA5, 8'hA5, 8'hA5, 8'hA5), 4'b0000, 8'h00, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (observe() !== e) begin
                n_fail++;
                $display("FAIL test_reset[%0d]: got %s, expected %s", k, fmt(observe()), fmt(e));
            end
        end
        n_checks++;
        if (dut.rr_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL test_reset rr_ptr: got %0d, expected 0", dut.rr_ptr);
        end
    endtask

    task automatic test_single_write();
        row_t t[$];
        obs_t e;
        do_reset();
        t.push_back(mk(0, 4'b0001, 4'b0001, d(8'h00, 8'h00, 8'h00, 8'hA5), 4'b0001, 8'h00, 1, 0));
        t.push_back(mk(0, 4'b0001, 4'b0001, d(8'h00, 8'h00, 8'h00, 8'hA5), 4'b0001, 8'hA5, 1, 0));
        t.push_back(mk(0, 4'b0000, 4'b0000, d(8'h00, 8'h00, 8'h00, 8'h00), 4'b0000, 8'hA5, 0, 0));
        t.push_back(mk(0, 4'b0000, 4'b0000, d(8'h00, 8'h00, 8'h00, 8'h00), 4'b0000, 8'hA5, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (observe() !== e) begin
                n_fail++;
                $display("FAIL test_single_write[%0d]: got %s, expected %s", k, fmt(observe()), fmt(e));
            end
        end
        n_checks++;
        if (dut.rr_ptr !== 2'd1) begin
            n_fail++;
            $display("FAIL test_single_write rr_ptr: got %0d, expected 1", dut.rr_ptr);
        end
    endtask

    // Includes a final write from the owner on the cycle it drops req.
    task automatic test_handoff();
        row_t t[$];
        obs_t e;
        do_reset();
        t.push_back(mk(0, 4'b0101, 4'b0000, d(8'h00, 8'h00, 8'h00, 8'h00), 4'b0001, 8'h00, 1, 0));
        t.push_back(mk(0, 4'b0100, 4'b0001, d(8'h00, 8'h00, 8'h00, 8'h77), 4'b0100, 8'h77, 1, 2));
        t.push_back(mk(0, 4'b0000, 4'b0000, d(8'h00, 8'h00, 8'h00, 8'h00), 4'b0000, 8'h77, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (observe() !== e) begin
                n_fail++;
                $display("FAIL test_handoff[%0d]: got %s, expected %s", k, fmt(observe()), fmt(e));
            end
        end
    endtask

    // Forced release after MAX_HOLD, then wrap-around from requester 3 to 0.
    task automatic test_hold_limit();
        row_t t[$];
        obs_t e;
        do_reset();
        t.push_back(mk(0, 4'b0010, 4'b0000, 32'h0, 4'b0010, 8'h00, 1, 1));
        repeat (3) t.push_back(mk(0, 4'b1010, 4'b0000, 32'h0, 4'b0010, 8'h00, 1, 1));
        t.push_back(mk(0, 4'b1010, 4'b0000, 32'h0, 4'b1000, 8'h00, 1, 3));
        foreach (t[k]) begin
            drive(t[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (observe() !== e) begin
                n_fail++;
                $display("FAIL test_hold_limit[%0d]: got %s, expected %s", k, fmt(observe()), fmt(e));
            end
        end
        n_checks++;
        if (dut.rr_ptr !== 2'd2) begin
            n_fail++;
            $display("FAIL test_hold_limit rr_ptr: got %0d, expected 2", dut.rr_ptr);
        end
        t.delete();
        t.push_back(mk(0, 4'b1001, 4'b0000, 32'h0, 4'b1000, 8'h00, 1, 3));
        t.push_back(mk(0, 4'b0001, 4'b0000, 32'h0, 4'b0001, 8'h00, 1, 0));
        foreach (t[k]) begin
            drive(t[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (observe() !== e) begin
                n_fail++;
                $display("FAIL test_wrap[%0d]: got %s, expected %s", k, fmt(observe()), fmt(e));
            end
        end
        n_checks++;
        if (dut.rr_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL test_wrap rr_ptr: got %0d, expected 0", dut.rr_ptr);
        end
    endtask

    // A lone owner keeps the grant indefinitely; the saturated counter still
    // forces release as soon as a competitor appears.
    task automatic test_saturation();
        row_t t[$];
        obs_t e;
        do_reset();
        repeat (7) t.push_back(mk(0, 4'b0100, 4'b0000, 32'h0, 4'b0100, 8'h00, 1, 2));
        t.push_back(mk(0, 4'b0110, 4'b0000, 32'h0, 4'b0010, 8'h00, 1, 1));
        t.push_back(mk(0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 8'h00, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (observe() !== e) begin
                n_fail++;
                $display("FAIL test_saturation[%0d]: got %s, expected %s", k, fmt(observe()), fmt(e));
            end
        end
    endtask

    task automatic test_nonowner_write();
        row_t t[$];
        obs_t e;
        do_reset();
        t.push_back(mk(0, 4'b0001, 4'b0000, d(8'h00, 8'h00, 8'h00, 8'h00), 4'b0001, 8'h00, 1, 0));
        t.push_back(mk(0, 4'b0001, 4'b0001, d(8'h00, 8'h00, 8'h00, 8'h11), 4'b0001, 8'h11, 1, 0));
        t.push_back(mk(0, 4'b0001, 4'b0100, d(8'h00, 8'h3C, 8'h00, 8'h99), 4'b0001, 8'h11, 1, 0));
        t.push_back(mk(0, 4'b0001, 4'b1110, d(8'h3C, 8'h3C, 8'h3C, 8'h99), 4'b0001, 8'h11, 1, 0));
        t.push_back(mk(0, 4'b0000, 4'b0000, d(8'h00, 8'h00, 8'h00, 8'h00), 4'b0000, 8'h11, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (observe() !== e) begin
                n_fail++;
                $display("FAIL test_nonowner_write[%0d]: got %s, expected %s", k, fmt(observe()), fmt(e));
            end
        end
    endtask

    // Reset while requester 1 owns and writes; arbitration restarts from 0.
    task automatic test_reset_in_own();
        row_t t[$];
        obs_t e;
        do_reset();
        t.push_back(mk(0, 4'b0001, 4'b0000, d(8'h00, 8'h00, 8'h00, 8'h00), 4'b0001, 8'h00, 1, 0));
        t.push_back(mk(0, 4'b0010, 4'b0000, d(8'h00, 8'h00, 8'h00, 8'h00), 4'b0010, 8'h00, 1, 1));
        t.push_back(mk(0, 4'b0010, 4'b0010, d(8'h00, 8'h00, 8'hEE, 8'h00), 4'b0010, 8'hEE, 1, 1));
        t.push_back(mk(1, 4'b0010, 4'b0010, d(8'h00, 8'h00, 8'h55, 8'h00), 4'b0000, 8'h00, 0, 0));
        t.push_back(mk(0, 4'b1010, 4'b0000, d(8'h00, 8'h00, 8'h00, 8'h00), 4'b0010, 8'h00, 1, 1));
        t.push_back(mk(0, 4'b0000, 4'b0000, d(8'h00, 8'h00, 8'h00, 8'h00), 4'b0000, 8'h00, 0, 0));
        foreach (t[k]) begin
            drive(t[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (observe() !== e) begin
                n_fail++;
                $display("FAIL test_reset_in_own[%0d]: got %s, expected %s", k, fmt(observe()), fmt(e));
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; wr_en = '0; wr_data = '0;
        test_reset();
        test_single_write();
        test_handoff();
        test_hold_limit();
        test_saturation();
        test_nonowner_write();
        test_reset_in_own();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
